// File: rtl/clock_period_meter.sv
// Clock period meter: measures the period and high time of an asynchronous
// input in clk cycles, flags loss of signal after TIMEOUT idle cycles.
module clock_period_meter #(
  parameter int unsigned    W       = 28,
  parameter logic [W-1:0]   TIMEOUT = W'(250_000_000)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sig_in,
  input  logic         clear,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;  // waiting for the first rise
  localparam logic [1:0] ST_ARMED = 2'd1;  // first rise seen, no full period yet
  localparam logic [1:0] ST_TRACK = 2'd2;  // periods being reported

  logic         s1;
  logic         s2;
  logic         s3;
  logic         rise_c;
  logic         fall_c;

  logic [1:0]   state;
  logic [1:0]   state_d;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_inc_c;
  logic         tmo_hit_c;
  logic [W-1:0] pend_high;
  logic [W-1:0] pend_high_d;
  logic [W-1:0] period_d;
  logic [W-1:0] high_time_d;
  logic         valid_d;
  logic         locked_d;
  logic         timeout_d;

  // Two-flop synchronizer plus history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c    = s2 & ~s3;
  assign fall_c    = ~s2 & s3;
  // cnt is bounded by TIMEOUT, so the increment can never wrap
  assign cnt_inc_c = cnt + W'(1);
  assign tmo_hit_c = (cnt_inc_c == TIMEOUT);

  // State and registered-output update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pend_high <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pend_high <= pend_high_d;
      period    <= period_d;
      high_time <= high_time_d;
      valid     <= valid_d;
      locked    <= locked_d;
      timeout   <= timeout_d;
    end
  end

  // Next-state and next-output logic; clear beats rise, rise beats timeout
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pend_high_d = pend_high;
    period_d    = period;
    high_time_d = high_time;
    valid_d     = 1'b0;
    locked_d    = locked;
    timeout_d   = timeout;

    if (clear) begin
      // Discard the measurement in progress; results and timeout are kept
      state_d     = ST_IDLE;
      cnt_d       = '0;
      pend_high_d = '0;
      locked_d    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise_c) begin
            state_d     = ST_ARMED;
            cnt_d       = '0;
            pend_high_d = '0;
          end
        end

        ST_ARMED, ST_TRACK: begin
          if (rise_c) begin
            // A full period closed: publish it and start the next one
            state_d     = ST_TRACK;
            period_d    = cnt_inc_c;
            high_time_d = pend_high;
            valid_d     = 1'b1;
            locked_d    = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = '0;
            pend_high_d = '0;
          end else if (tmo_hit_c) begin
            // Loss of signal: drop lock but keep the last reported values
            state_d     = ST_IDLE;
            cnt_d       = '0;
            pend_high_d = '0;
            locked_d    = 1'b0;
            timeout_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc_c;
            if (fall_c) begin
              pend_high_d = cnt_inc_c;
            end
          end
        end

        default: begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          pend_high_d = '0;
          locked_d    = 1'b0;
        end
      endcase
    end
  end

endmodule
